// File: rtl/maze_stepper.sv
// -----------------------------------------------------------------------------
// maze_stepper -- depth-first "rat in a maze" walker.
//
// Starting at (0,0) the rat probes its four neighbours in the order up, right,
// down, left.  Each probe drives the candidate cell on row/colomn for two
// cycles (ISSUE with rd_en, then CHECK) and an external checker answers with
// return_ornot (1 = out of range or wall).  Accepted moves push the direction
// taken on a 256 x 2-bit stack.  When all four directions of a cell are
// exhausted the walker pops back toward the root.  Reaching TGT_ROW/TGT_COL
// ends in DONE, exhausting the root (or overflowing the stack) ends in FAIL.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         1-cycle pulse, starts a search when not busy
//   return_ornot  checker reject flag, sampled at the end of CHECK
//   row, colomn   candidate cell (checker + maze memory address)
//   rd_en         maze memory read strobe, high during ISSUE
//   wr_en         visited-mark write strobe (data 1) at row/colomn
//   cur_row/col   current rat position
//   busy          high outside IDLE, DONE and FAIL
//   done, fail    held high in DONE / FAIL
//
// Configuration macro
//   MAZE_VISIT_MARK_EN  when defined, every MOVE writes a mark at the new
//                       cell so it reads back as a wall and is never
//                       re-entered.  When undefined wr_en is tied low and
//                       cyclic mazes end via stack overflow.
// -----------------------------------------------------------------------------
module maze_stepper #(
    parameter logic [7:0] TGT_ROW = 8'd15,
    parameter logic [7:0] TGT_COL = 8'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       return_ornot,
    output logic [7:0] row,
    output logic [7:0] colomn,
    output logic       rd_en,
    output logic       wr_en,
    output logic [7:0] cur_row,
    output logic [7:0] cur_col,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CHECK = 3'd2,
        MOVE  = 3'd3,
        BACK  = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    state_t     state;
    state_t     nxt;
    logic [1:0] dir;
    logic [7:0] sp;
    logic [1:0] stack [256];
    logic [1:0] top_dir;
    logic       is_parent;
    logic       push;

    logic [7:0] n_row;
    logic [7:0] n_col;
    logic [1:0] n_dir;
    logic [7:0] n_sp;

    // Row/column offsets of a direction, as 8-bit modulo values so that
    // 0 - 1 wraps to 255 and is rejected by the checker as out of range.
    function automatic logic [7:0] off_row(input logic [1:0] d);
        case (d)
            DIR_UP:   off_row = 8'hFF;
            DIR_DOWN: off_row = 8'h01;
            default:  off_row = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] off_col(input logic [1:0] d);
        case (d)
            DIR_RIGHT: off_col = 8'h01;
            DIR_LEFT:  off_col = 8'hFF;
            default:   off_col = 8'h00;
        endcase
    endfunction

    // Direction used to enter the current cell.  Only meaningful when sp != 0;
    // at sp = 0 the read wraps to entry 255 and is masked below.
    assign top_dir = stack[sp - 8'd1];

    // Stepping in the opposite of the entry direction lands on the parent.
    assign is_parent = (sp != 8'd0) && (dir == (top_dir ^ 2'd2));

    // A full stack (255 entries) refuses the push and the MOVE fails.
    assign push = (state == MOVE) && (sp != 8'd255);

    // Stack RAM: no reset needed, entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= dir;
    end

    // Next-state and next-position logic.
    always_comb begin
        nxt   = state;
        n_row = cur_row;
        n_col = cur_col;
        n_dir = dir;
        n_sp  = sp;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    n_row = 8'd0;
                    n_col = 8'd0;
                    n_dir = DIR_UP;
                    n_sp  = 8'd0;
                    if (TGT_ROW == 8'd0 && TGT_COL == 8'd0) nxt = DONE;
                    else                                    nxt = ISSUE;
                end
            end
            ISSUE: nxt = CHECK;
            CHECK: begin
                if (!return_ornot && !is_parent) begin
                    nxt = MOVE;
                end else if (dir != DIR_LEFT) begin
                    n_dir = dir + 2'd1;
                    nxt   = ISSUE;
                end else if (sp == 8'd0) begin
                    nxt = FAIL;
                end else begin
                    nxt = BACK;
                end
            end
            MOVE: begin
                if (sp == 8'd255) begin
                    nxt = FAIL;
                end else begin
                    // row/colomn still hold the accepted candidate.
                    n_sp  = sp + 8'd1;
                    n_row = row;
                    n_col = colomn;
                    n_dir = DIR_UP;
                    if (row == TGT_ROW && colomn == TGT_COL) nxt = DONE;
                    else                                     nxt = ISSUE;
                end
            end
            BACK: begin
                // Undo the step that entered this cell, then resume the parent
                // at the direction after the one just popped.
                n_sp  = sp - 8'd1;
                n_row = cur_row - off_row(top_dir);
                n_col = cur_col - off_col(top_dir);
                if (top_dir != DIR_LEFT) begin
                    n_dir = top_dir + 2'd1;
                    nxt   = ISSUE;
                end else if (sp == 8'd1) begin
                    nxt = FAIL;
                end else begin
                    nxt = BACK;
                end
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef MAZE_VISIT_MARK_EN
    logic mark_q;
    assign wr_en = mark_q;
`else
    assign wr_en = 1'b0;
`endif

    // State register and registered outputs, all derived from the next state
    // so every strobe lines up with the cycle of the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_row <= 8'd0;
            cur_col <= 8'd0;
            dir     <= DIR_UP;
            sp      <= 8'd0;
            row     <= 8'd0;
            colomn  <= 8'd0;
            rd_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
`ifdef MAZE_VISIT_MARK_EN
            mark_q  <= 1'b0;
`endif
        end else begin
            state   <= nxt;
            cur_row <= n_row;
            cur_col <= n_col;
            dir     <= n_dir;
            sp      <= n_sp;
            if (nxt == ISSUE) begin
                row    <= n_row + off_row(n_dir);
                colomn <= n_col + off_col(n_dir);
            end
            rd_en   <= (nxt == ISSUE);
            busy    <= (nxt != IDLE) && (nxt != DONE) && (nxt != FAIL);
            done    <= (nxt == DONE);
            fail    <= (nxt == FAIL);
`ifdef MAZE_VISIT_MARK_EN
            // MOVE never follows ISSUE, so this cannot overlap rd_en.
            mark_q  <= (nxt == MOVE);
`endif
        end
    end

endmodule

// File: doc/maze_stepper.md
MAZE_STEPPER -- requirements
Module: maze_stepper

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port start  input  1  single-cycle pulse; begins a search from (0,0) when the block is idle.
REQ-004 SHALL have port return_ornot  input  1  reject flag from the downstream bounds/wall checker, valid in CHECK.
REQ-005 SHALL have port row  output  8  candidate row; drives both the checker and the maze memory address.
REQ-006 SHALL have port colomn  output  8  candidate column; drives both the checker and the maze memory address.
REQ-007 SHALL have port rd_en  output  1  maze memory read strobe; memory dout is valid one cycle later.
REQ-008 SHALL have port wr_en  output  1  visited-mark write strobe at (row,colomn), data 1.
REQ-009 SHALL have port cur_row  output  8  current rat row.
REQ-010 SHALL have port cur_col  output  8  current rat column.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE, DONE and FAIL.
REQ-012 SHALL have port done  output  1  held high in DONE.
REQ-013 SHALL have port fail  output  1  held high in FAIL.

Function
REQ-014 SHALL implement states IDLE, ISSUE, CHECK, MOVE, BACK, DONE, FAIL.
REQ-015 SHALL encode directions as 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1); candidate arithmetic SHALL be 8-bit modulo, so 0-1 yields 8'd255, which the checker rejects as out of range.
REQ-016 IDLE + start: cur=(0,0), dir=0, stack pointer sp=0 -> DONE if the target equals (0,0); otherwise -> ISSUE.
REQ-017 ISSUE (1 cycle): row/colomn = cur + dir offset; rd_en=1 -> CHECK.
REQ-018 CHECK (1 cycle): row/colomn held; return_ornot sampled at the clock edge.
REQ-019 A probe SHALL take exactly 2 cycles from ISSUE entry to the decision.
REQ-020 CHECK, return_ornot=0 and candidate is not the parent cell -> MOVE.
REQ-021 CHECK, rejected (including candidate equal to parent) and dir<3 -> dir+1 -> ISSUE.
REQ-022 CHECK, rejected and dir=3: sp=0 -> FAIL; else -> BACK.
REQ-023 MOVE (1 cycle): push dir at stack[sp], sp+1; cur = candidate; dir=0 -> DONE if cur=(15,15); otherwise -> ISSUE.
REQ-024 MOVE with sp=255 (stack full, 255 entries in use) SHALL go to FAIL without pushing.
REQ-025 BACK (1 cycle): sp-1; pop d; cur = cur minus offset of d.
REQ-026 BACK, d<3: dir=d+1 -> ISSUE.
REQ-027 BACK, d=3: stays in BACK for the next pop, or -> FAIL when sp reaches 0.
REQ-028 Stack SHALL be 256 x 2 bits; the parent direction SHALL be the opposite of stack[sp-1], and there is no parent when sp=0.
REQ-029 DONE/FAIL SHALL hold cur_row/cur_col; start SHALL restart the search per REQ-016; start while busy SHALL be ignored.
REQ-030 rd_en and wr_en SHALL never be high in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, with row=colomn=cur_row=cur_col=0, sp=0, dir=0, and rd_en=wr_en=busy=done=fail=0.
REQ-032 Stack contents SHALL need no reset; reset mid-search SHALL abandon the search with no further memory access.

Configuration
REQ-033 With MAZE_VISIT_MARK_EN defined, MOVE SHALL assert wr_en=1 for 1 cycle with row/colomn = new cell, marking it as a wall so it is never re-entered; DFS then terminates on any maze.
REQ-034 Without MAZE_VISIT_MARK_EN, wr_en SHALL be tied 0, only the parent-cell rule prevents immediate reversal, and cyclic mazes terminate via the stack-full FAIL of REQ-024.

Verification
REQ-035 Open maze (all dout=0), start -> first probe row=255,colomn=0 rejected, then (0,1) accepted; path right along row 0 to (0,15), then down to (15,15); done=1, sp=30.
REQ-036 Wall at (0,1) and (1,0) only, start -> all 4 directions rejected at sp=0 -> fail=1 after 4 probes (8 cycles + 1 for start).
REQ-037 Dead end: corridor (0,0)->(0,1)->(0,2), all else walls -> BACK twice, cur returns to (0,0), then fail=1.
REQ-038 rst_n pulsed low during CHECK mid-search -> same cycle outputs zero, busy=0; a later start runs REQ-035 identically.
REQ-039 With MAZE_VISIT_MARK_EN, 2x2 loop region -> wr_en seen once per entered cell, no cell entered twice, done=1; without the macro, the same maze with the target walled off -> fail=1 via stack full.
REQ-040 start asserted while busy -> no effect on state, sp or cur; rd_en/wr_en never both high (assertion active throughout all scenarios).
